// File: rtl/lane_scheduler.sv
// lane_scheduler: game-state controller for the five falling-block lanes
// (green, yellow, blue, orange, white) of the rhythm display.
// It spawns blocks from the upstream pattern stream, advances them once per
// frame, judges button presses against the hit zone, and keeps score/misses.
//
// Optional feature macro: COMBO_MULT_EN (combo counter and score multiplier).
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   frame_tick          one-cycle pulse per video frame
//   start, pause        game control levels
//   button[4:0]         lane buttons (bit0 = green .. bit4 = white)
//   pattern_lanes/valid upstream spawn pattern; pattern_ready pulses on consume
//   block_valid/block_y slot occupancy and top row, index lane*N_SLOTS+slot
//   score, miss_count   game counters
//   hit_pulse[4:0]      one-cycle pulse per lane on a successful hit
//   state               0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
//   overflow            sticky: a spawn was dropped because the lane was full
//   combo               consecutive-hit count (0 when COMBO_MULT_EN undefined)
module lane_scheduler #(
    parameter int unsigned N_SLOTS      = 4,
    parameter int unsigned SPEED        = 4,
    parameter int unsigned SPAWN_FRAMES = 30,
    parameter int unsigned HIT_TOP      = 426,
    parameter int unsigned HIT_BOT      = 470,
    parameter int unsigned MISS_ROW     = 479,
    parameter int unsigned HIT_POINTS   = 10,
    parameter int unsigned MAX_MISSES   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    start,
    input  logic                    pause,
    input  logic [4:0]              button,
    input  logic [4:0]              pattern_lanes,
    input  logic                    pattern_valid,
    output logic                    pattern_ready,
    output logic [5*N_SLOTS-1:0]    block_valid,
    output logic [10*5*N_SLOTS-1:0] block_y,
    output logic [16:0]             score,
    output logic [3:0]              miss_count,
    output logic [4:0]              hit_pulse,
    output logic [1:0]              state,
    output logic                    overflow,
    output logic [6:0]              combo
);
    localparam int unsigned NB   = 5 * N_SLOTS;
    localparam int unsigned IdxW = $clog2(NB);
    localparam int unsigned CntW = $clog2(SPAWN_FRAMES);

    localparam logic [9:0]      Speed    = 10'(SPEED);
    localparam logic [9:0]      HitTop   = 10'(HIT_TOP);
    localparam logic [9:0]      HitBot   = 10'(HIT_BOT);
    localparam logic [9:0]      MissRow  = 10'(MISS_ROW);
    localparam logic [3:0]      MaxMiss  = 4'(MAX_MISSES);
    localparam logic [CntW-1:0] CntMax   = CntW'(SPAWN_FRAMES - 1);
    localparam logic [17:0]     ScoreMax = 18'd99999;

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StPaused = 2'd2, StDone = 2'd3} state_e;

    state_e               st_q, st_d;
    logic [NB-1:0]        valid_q, valid_d;
    logic [NB-1:0][9:0]   y_q, y_d;
    logic [16:0]          score_q, score_d;
    logic [3:0]           miss_q, miss_d;
    logic [4:0]           hit_q, hit_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 prdy_q, prdy_d;
    logic [4:0]           btn_q;

    logic [4:0]           press;
    logic                 run, clear, found, placed;
    logic [IdxW-1:0]      best;
    logic [9:0]           best_y, ny;
    logic [2:0]           nhits;
    logic [7:0]           nmiss;
    logic [8:0]           miss_sum;
    logic [17:0]          pts, score_sum;

    assign press = button & ~btn_q;

`ifdef COMBO_MULT_EN
    logic [6:0] combo_q, combo_d;
    logic [7:0] combo_sum;
    logic [2:0] mult;

    // Multiplier uses the combo value from before this cycle's hits.
    assign mult      = (combo_q >= 7'd30) ? 3'd4 : 3'(combo_q / 7'd10) + 3'd1;
    assign pts       = 18'(HIT_POINTS) * {15'b0, mult};
    assign combo_sum = {1'b0, combo_q} + {5'b0, nhits};
    assign combo     = combo_q;

    always_comb begin
        combo_d = combo_q;
        if (clear || nmiss != 8'd0) begin
            combo_d = '0;
        end else if (nhits != 3'd0) begin
            combo_d = (combo_sum > 8'd127) ? 7'd127 : combo_sum[6:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) combo_q <= '0;
        else       combo_q <= combo_d;
    end
`else
    assign pts   = 18'(HIT_POINTS);
    assign combo = '0;
`endif

    always_comb begin
        st_d      = st_q;
        valid_d   = valid_q;
        y_d       = y_q;
        score_d   = score_q;
        miss_d    = miss_q;
        hit_d     = '0;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        prdy_d    = 1'b0;
        run       = 1'b0;
        clear     = 1'b0;
        found     = 1'b0;
        placed    = 1'b0;
        best      = '0;
        best_y    = '0;
        ny        = '0;
        nhits     = '0;
        nmiss     = '0;
        miss_sum  = '0;
        score_sum = '0;

        unique case (st_q)
            StIdle, StDone: begin
                if (start) begin
                    st_d  = StRun;
                    clear = 1'b1;
                end
            end
            StPaused: if (!pause) st_d = StRun;
            StRun: begin
                if (pause) st_d = StPaused;
                else       run  = 1'b1;
            end
        endcase

        if (clear) begin
            valid_d = '0;
            y_d     = '0;
            score_d = '0;
            miss_d  = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end

        if (run) begin
            // Judge presses on pre-advance positions: deepest eligible block wins,
            // strict '>' keeps the lowest slot index on ties.
            for (int l = 0; l < 5; l++) begin
                found  = 1'b0;
                best   = '0;
                best_y = '0;
                for (int s = 0; s < int'(N_SLOTS); s++) begin
                    if (valid_q[l*N_SLOTS+s] && y_q[l*N_SLOTS+s] >= HitTop &&
                        y_q[l*N_SLOTS+s] <= HitBot && (!found || y_q[l*N_SLOTS+s] > best_y)) begin
                        found  = 1'b1;
                        best   = IdxW'(l * N_SLOTS + s);
                        best_y = y_q[l*N_SLOTS+s];
                    end
                end
                if (press[l] && found) begin
                    hit_d[l]      = 1'b1;
                    valid_d[best] = 1'b0;
                    y_d[best]     = '0;
                    nhits         = nhits + 3'd1;
                end
            end

            if (frame_tick) begin
                // Blocks hit this cycle already dropped out of valid_d.
                for (int b = 0; b < int'(NB); b++) begin
                    if (valid_d[b]) begin
                        ny = y_q[b] + Speed;
                        if (ny > MissRow) begin
                            valid_d[b] = 1'b0;
                            y_d[b]     = '0;
                            nmiss      = nmiss + 8'd1;
                        end else begin
                            y_d[b] = ny;
                        end
                    end
                end

                if (cnt_q == CntMax) begin
                    cnt_d = '0;
                    if (pattern_valid) begin
                        prdy_d = 1'b1;
                        // Free means free at the start of the cycle (valid_q).
                        for (int l = 0; l < 5; l++) begin
                            placed = 1'b0;
                            for (int s = 0; s < int'(N_SLOTS); s++) begin
                                if (pattern_lanes[l] && !placed && !valid_q[l*N_SLOTS+s]) begin
                                    valid_d[l*N_SLOTS+s] = 1'b1;
                                    y_d[l*N_SLOTS+s]     = '0;
                                    placed               = 1'b1;
                                end
                            end
                            if (pattern_lanes[l] && !placed) ovf_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            score_sum = {1'b0, score_q} + pts * {15'b0, nhits};
            score_d   = (score_sum > ScoreMax) ? ScoreMax[16:0] : score_sum[16:0];

            miss_sum = {5'b0, miss_q} + {1'b0, nmiss};
            miss_d   = (miss_sum >= {5'b0, MaxMiss}) ? MaxMiss : miss_sum[3:0];
            if (miss_d == MaxMiss) st_d = StDone;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q    <= StIdle;
            valid_q <= '0;
            y_q     <= '0;
            score_q <= '0;
            miss_q  <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            prdy_q  <= 1'b0;
            btn_q   <= '0;
        end else begin
            st_q    <= st_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            prdy_q  <= prdy_d;
            // History tracks in every state so a held button never re-fires.
            btn_q   <= button;
        end
    end

    assign pattern_ready = prdy_q;
    assign block_valid   = valid_q;
    assign block_y       = y_q;
    assign score         = score_q;
    assign miss_count    = miss_q;
    assign hit_pulse     = hit_q;
    assign state         = st_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Directed testbench for lane_scheduler (default parameters).
// Expected values are hand-computed from frame counts since the last start:
// spawns happen on every 30th frame, blocks fall 4 rows per frame.
module tb_lane_scheduler;
    logic         clk = 1'b0;
    logic         reset;
    logic         frame_tick;
    logic         start;
    logic         pause;
    logic [4:0]   button;
    logic [4:0]   pattern_lanes;
    logic         pattern_valid;
    logic         pattern_ready;
    logic [19:0]  block_valid;
    logic [199:0] block_y;
    logic [16:0]  score;
    logic [3:0]   miss_count;
    logic [4:0]   hit_pulse;
    logic [1:0]   state;
    logic         overflow;
    logic [6:0]   combo;

    int          checks   = 0;
    int          failures = 0;
    int          prdy_cnt = 0;
    logic [4:0]  last_hit;

    lane_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .start         (start),
        .pause         (pause),
        .button        (button),
        .pattern_lanes (pattern_lanes),
        .pattern_valid (pattern_valid),
        .pattern_ready (pattern_ready),
        .block_valid   (block_valid),
        .block_y       (block_y),
        .score         (score),
        .miss_count    (miss_count),
        .hit_pulse     (hit_pulse),
        .state         (state),
        .overflow      (overflow),
        .combo         (combo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n back-to-back frame ticks; counts pattern_ready pulses seen.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            if (pattern_ready) prdy_cnt++;
        end
    endtask

    task automatic press(input logic [4:0] m);
        button = m;
        cyc();
        last_hit = hit_pulse;
        button = '0;
        cyc();
    endtask

    function automatic logic [9:0] yof(input int idx);
        return block_y[idx*10 +: 10];
    endfunction

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; pause = 1'b0;
        button = '0; pattern_lanes = '0; pattern_valid = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        check("rst_state", state, 0);
        check("rst_valid", block_valid, 0);
        check("rst_score", score, 0);
        check("rst_overflow", overflow, 0);
        check("rst_combo", combo, 0);

        // Single green block: spawn on frame 30, hit at y=428.
        start = 1'b1; cyc(); start = 1'b0;
        check("start_run", state, 1);
        pattern_lanes = 5'b00001; pattern_valid = 1'b1;
        prdy_cnt = 0;
        ticks(30);
        pattern_valid = 1'b0;
        check("spawn_ready_once", prdy_cnt, 1);
        check("spawn_valid", block_valid, 20'h00001);
        check("spawn_y0", yof(0), 0);
        ticks(107);                                       // frame 137
        check("fall_y428", yof(0), 428);
        press(5'b00001);
        check("hit_pulse_g", last_hit, 5'b00001);
        check("hit_score10", score, 10);
        check("hit_cleared", block_valid, 0);

        // Green + white at 440, pressed together.
        pattern_lanes = 5'b10001; pattern_valid = 1'b1;
        ticks(13);                                        // frame 150 spawn
        pattern_valid = 1'b0;
        check("dual_spawn", block_valid, 20'h10001);
        ticks(110);                                       // frame 260
        check("white_y440", yof(16), 440);
        press(5'b10001);
        check("dual_pulse", last_hit, 5'b10001);
        check("dual_score30", score, 30);

        // Press above the hit zone (y=400) does nothing.
        pattern_lanes = 5'b00001; pattern_valid = 1'b1;
        ticks(10);                                        // frame 270 spawn
        pattern_valid = 1'b0;
        ticks(100);                                       // frame 370, y=400
        press(5'b00001);
        check("early_no_pulse", last_hit, 0);
        check("early_score", score, 30);
        check("early_kept", block_valid, 20'h00001);
        ticks(20);                                        // frame 390, y=480 -> miss
        check("miss1", miss_count, 1);
        check("miss1_clear", block_valid, 0);

        // Fill green lane; 5th spawn lands on the cycle slot0 misses -> dropped.
        pattern_valid = 1'b1;
        prdy_cnt = 0;
        ticks(149);                                       // frame 539
        check("full_valid", block_valid, 20'h0000F);
        check("full_no_ovf", overflow, 0);
        ticks(1);                                         // frame 540
        pattern_valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_miss2", miss_count, 2);
        check("ovf_valid", block_valid, 20'h0000E);
        check("ovf_ready5", prdy_cnt, 5);
        check("ovf_y1", yof(1), 360);
        ticks(17);                                        // frame 557, slot1=428

        // Pause with button held: nothing moves, no hit on resume.
        pause = 1'b1; cyc();
        check("paused", state, 2);
        button = 5'b00001;
        ticks(10);
        check("pause_y", yof(1), 428);
        check("pause_nohit", hit_pulse, 0);
        pause = 1'b0; cyc();
        check("resume", state, 1);
        cyc();
        check("held_nohit", hit_pulse, 0);
        check("held_score", score, 30);
        button = '0; cyc();
        press(5'b00001);
        check("resume_hit", last_hit, 5'b00001);
        check("resume_score", score, 40);
        ticks(41);                                        // frame 598, slot2=472
        check("y472", yof(2), 472);
        press(5'b00001);
        check("below_zone_nohit", last_hit, 0);

        // Run misses up to saturation at 8.
        pattern_lanes = 5'b11111; pattern_valid = 1'b1;
        ticks(2);                                         // frame 600
        check("all_spawn", block_valid, 20'h11119);
        check("miss3", miss_count, 3);
        pattern_lanes = 5'b00001;
        ticks(30);                                        // frame 630
        pattern_valid = 1'b0;
        check("reuse_slot1", block_valid, 20'h11113);
        check("miss4", miss_count, 4);
        ticks(89);                                        // frame 719
        check("still_run", state, 1);
        ticks(1);                                         // frame 720
        check("miss_sat8", miss_count, 8);
        check("done", state, 3);
        check("done_valid", block_valid, 20'h00002);
        check("done_y", yof(1), 360);
        pattern_lanes = 5'b11111; pattern_valid = 1'b1;
        prdy_cnt = 0;
        ticks(30);
        pattern_valid = 1'b0;
        check("done_frozen_y", yof(1), 360);
        check("done_no_ready", prdy_cnt, 0);
        start = 1'b1; cyc(); start = 1'b0;
        check("restart_run", state, 1);
        check("restart_valid", block_valid, 0);
        check("restart_score", score, 0);
        check("restart_miss", miss_count, 0);
        check("restart_ovf", overflow, 0);

        // Eleven hits then a miss (combo multiplier when enabled).
        pattern_lanes = 5'b11111; pattern_valid = 1'b1;
        ticks(60);
        pattern_lanes = 5'b00001;
        ticks(30);                                        // frame 90
        pattern_valid = 1'b0;
        ticks(47);                                        // frame 137
        press(5'b11111);
        check("c5_pulse", last_hit, 5'b11111);
        check("c5_score", score, 50);
        ticks(30);                                        // frame 167
        press(5'b11111);
        check("c10_score", score, 100);
`ifdef COMBO_MULT_EN
        check("c10_combo", combo, 10);
`else
        check("c10_combo", combo, 0);
`endif
        ticks(30);                                        // frame 197
        press(5'b00001);
`ifdef COMBO_MULT_EN
        check("c11_score", score, 120);
        check("c11_combo", combo, 11);
`else
        check("c11_score", score, 110);
`endif
        pattern_valid = 1'b1;
        ticks(13);                                        // frame 210 spawn
        pattern_valid = 1'b0;
        ticks(120);                                       // frame 330 miss
        check("c_miss", miss_count, 1);
        check("c_combo0", combo, 0);

        // Reset in the middle of RUN with three live blocks.
        pattern_lanes = 5'b00111; pattern_valid = 1'b1;
        ticks(30);                                        // frame 360 spawn
        pattern_valid = 1'b0;
        check("pre_rst_valid", block_valid, 20'h00111);
        reset = 1'b1; cyc();
        check("mid_rst_state", state, 0);
        check("mid_rst_valid", block_valid, 0);
        check("mid_rst_score", score, 0);
        check("mid_rst_miss", miss_count, 0);
        reset = 1'b0; cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lane_scheduler.md
Name: lane_scheduler

Overview:
Game-state controller that sequences the five falling-block lanes (green, yellow, blue, orange, white) of the rhythm display. It spawns blocks from an upstream pattern stream, advances them once per video frame, and judges button presses against the hit zone. It maintains the score and miss count. It feeds block positions and the 17-bit score value to the screen generator, which draws from these registers only.

Parameters:
N_SLOTS, 4, max simultaneous blocks per lane
SPEED, 4, rows advanced per frame_tick
SPAWN_FRAMES, 30, frame_ticks between pattern consumptions
HIT_TOP, 426, lowest block y (inclusive) counted as a hit
HIT_BOT, 470, highest block y (inclusive) counted as a hit
MISS_ROW, 479, block with y > MISS_ROW is a miss
HIT_POINTS, 10, score added per hit
MAX_MISSES, 8, misses that end the game

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank
start  in  1  level; begin/restart game
pause  in  1  level; freeze game while high in RUN
button  in  5  lane buttons, synchronised upstream; bit0 = green … bit4 = white
pattern_lanes  in  5  lanes to spawn in the next spawn event
pattern_valid  in  1  pattern_lanes is valid
pattern_ready  out  1  one-cycle pulse; pattern word consumed
block_valid  out  5*N_SLOTS  slot occupied; index lane*N_SLOTS+slot
block_y  out  10*5*N_SLOTS  block top row per slot, same indexing
score  out  17  current score, 0..99999
miss_count  out  4  misses this game
hit_pulse  out  5  one-cycle pulse per lane on a successful hit
state  out  2  0 IDLE, 1 RUN, 2 PAUSED, 3 DONE
overflow  out  1  sticky; spawn dropped because lane full
combo  out  7  consecutive-hit count (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE, all block_valid=0, block_y=0, score=0, miss_count=0, combo=0, spawn counter=0, overflow=0, pattern_ready=0, hit_pulse=0, button history=0.
- All outputs are registered. Effects appear the cycle after the triggering input.
- IDLE: start=1 -> RUN.
- RUN: pause=1 -> PAUSED. miss_count reaching MAX_MISSES -> DONE. start is ignored.
- PAUSED: pause=0 -> RUN. frame_tick and button are ignored. Button history keeps updating, so a button held through the pause does not fire on resume.
- DONE: start=1 clears blocks, score, miss_count, combo, spawn counter and overflow, then -> RUN. The same clear occurs on IDLE->RUN.
- Press = rising edge of button[i] (previous-cycle register). Judged only in RUN.
  - On press, find occupied slots in lane i with HIT_TOP <= y <= HIT_BOT.
  - If any exist, clear the one with the largest y (ties: lowest slot index). Pulse hit_pulse[i] and add points.
  - A press with no eligible block has no effect.
- Several lanes pressed in one cycle: every lane is judged. score += hits*HIT_POINTS, saturating at 99999.
- frame_tick in RUN:
  - Each occupied slot not cleared this cycle gets y += SPEED.
  - A slot whose new y > MISS_ROW is cleared and miss_count += 1 per cleared slot. miss_count saturates at MAX_MISSES.
- Spawn: on frame_tick in RUN, the spawn counter increments and wraps at SPAWN_FRAMES-1. On wrap:
  - If pattern_valid=1, pulse pattern_ready.
  - For each set bit of pattern_lanes, fill the lowest free slot with y=0.
  - Free = unoccupied at the start of the cycle; slots freed this cycle are not reused until the next spawn.
  - If a lane is full, drop its spawn and set overflow.
  - If pattern_valid=0, no spawn occurs and the counter still wraps.
- Same-cycle press and frame_tick: the hit is judged on pre-advance y, and the hit block is not advanced.
- Same-cycle last miss and a hit: score still updates, then -> DONE.

Optional Feature:
COMBO_MULT_EN:
- Defined:
  - combo increments per hit (saturates at 127) and resets to 0 on any miss.
  - Points per hit = HIT_POINTS * (1 + min(combo/10, 3)), using combo before this cycle's increment.
- Undefined: combo is tied to 0 and points per hit = HIT_POINTS.

Test Plan:
- Reset mid-RUN with 3 blocks live -> next cycle state=0, all block_valid=0, score=0, miss_count=0.
- start, pattern_lanes=5'b00001 valid, 30 frame_ticks -> pattern_ready pulses once, green slot0 valid, y=0. After 107 further ticks, y=428. Press button[0] -> hit_pulse[0]=1, score=10, slot0 cleared.
- Green and white blocks both at y=440, both buttons rise in the same cycle -> hit_pulse=5'b10001, score +20. Press with a block at y=400 -> no change.
- 8 blocks allowed to pass y>479 -> miss_count=8, state=DONE. Further frame_ticks leave y frozen. start -> RUN, everything cleared.
- 5 spawns into green without hits (N_SLOTS=4) -> 5th dropped, overflow=1. pause=1 across 10 frame_ticks -> all y unchanged.
- COMBO_MULT_EN: 10 consecutive hits -> score=100, 11th hit adds 20, then one miss -> combo=0.
